// File: rtl/defs_pkg.sv
// Shared definitions for the AXI read path.
//   AxiIdW : width of the master-side AR/R ID fields.
package defs_pkg;
  parameter int unsigned AxiIdW = 4;
endpackage

// File: rtl/axi_rd_arb_if.sv
// Bundle of all handshake/bus signals around axi_rd_arb.
//   master : view used by the arbiter itself (drives s_arready, s_rvalid, s_r,
//            s_rlast, m_arvalid, m_ar, m_arid, m_rready, rid_err).
//   slave  : view used by the surrounding requesters and AXI slave.
interface axi_rd_arb_if #(
  parameter int unsigned AxiIdW = defs_pkg::AxiIdW
);
  // requester side (index 0 = IFU fetch, 1 = LSU load)
  logic [1:0]        s_arvalid;
  logic [1:0]        s_arready;
  logic [1:0][44:0]  s_ar;       // {araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0]}
  logic [1:0]        s_flush;
  logic [1:0]        s_rvalid;
  logic [1:0]        s_rready;
  logic [65:0]       s_r;        // {rdata[63:0], rresp[1:0]}
  logic              s_rlast;
  // master side
  logic              m_arvalid;
  logic              m_arready;
  logic [44:0]       m_ar;
  logic [AxiIdW-1:0] m_arid;
  logic              m_rvalid;
  logic              m_rready;
  logic [AxiIdW-1:0] m_rid;
  logic [65:0]       m_r;
  logic              m_rlast;
  logic              rid_err;

  modport master (
    input  s_arvalid, s_ar, s_flush, s_rready,
           m_arready, m_rvalid, m_rid, m_r, m_rlast,
    output s_arready, s_rvalid, s_r, s_rlast,
           m_arvalid, m_ar, m_arid, m_rready, rid_err
  );

  modport slave (
    output s_arvalid, s_ar, s_flush, s_rready,
           m_arready, m_rvalid, m_rid, m_r, m_rlast,
    input  s_arready, s_rvalid, s_r, s_rlast,
           m_arvalid, m_ar, m_arid, m_rready, rid_err
  );
endinterface

// File: rtl/axi_rd_arb.sv
// Two-requester AXI read arbiter (IFU fetch = 0, LSU load = 1) with a single
// outstanding burst. Round-robin pointer flips to the other requester after
// each completed burst. A flush from the granted requester turns the rest of
// its burst into a drain (beats accepted and discarded). rid_err is a sticky
// flag for R beats whose ID does not match the issued AR ID.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : axi_rd_arb_if.master (requester AR/R channels, master AR/R, rid_err)
module axi_rd_arb #(
  parameter int unsigned AxiIdW = defs_pkg::AxiIdW,
  parameter int unsigned NReq   = 2
) (
  input logic          clk,
  input logic          rst_n,
  axi_rd_arb_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e      state_q;
  logic        grant_q;
  logic        ptr_q;
  logic        drop_q;
  logic [44:0] payload_q;
  logic        rid_err_q;

  logic              grant_sel;
  logic              req_any;
  logic              flush_now;
  logic              drop_eff;
  logic              beat_hs;
  logic [NReq-1:0]   arready_c;
  logic [NReq-1:0]   rvalid_c;
  logic              m_arvalid_c;
  logic [44:0]       m_ar_c;
  logic [AxiIdW-1:0] m_arid_c;
  logic              m_rready_c;
  logic [65:0]       s_r_c;
  logic              s_rlast_c;

  always_comb begin
    grant_sel   = bus.s_arvalid[ptr_q] ? ptr_q : ~ptr_q;
    req_any     = |bus.s_arvalid;
    flush_now   = bus.s_flush[grant_q] && (state_q != IDLE);
    // A flush in the same cycle as a beat must already suppress that beat.
    drop_eff    = drop_q | flush_now;
    m_arid_c    = AxiIdW'(grant_q);
    arready_c   = '0;
    rvalid_c    = '0;
    m_arvalid_c = 1'b0;
    m_ar_c      = '0;
    m_rready_c  = 1'b0;
    s_r_c       = '0;
    s_rlast_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so the grant ready is 0 while reset is held.
        if (req_any && rst_n) arready_c[grant_sel] = 1'b1;
      end
      ADDR: begin
        m_arvalid_c = 1'b1;
        m_ar_c      = payload_q;
      end
      DATA: begin
        s_r_c      = bus.m_r;
        s_rlast_c  = bus.m_rlast;
        m_rready_c = drop_eff ? 1'b1 : bus.s_rready[grant_q];
        rvalid_c[grant_q] = bus.m_rvalid & ~drop_eff;
      end
      default: ;
    endcase
    beat_hs = (state_q == DATA) && bus.m_rvalid && m_rready_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      ptr_q     <= 1'b0;
      drop_q    <= 1'b0;
      payload_q <= '0;
      rid_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_any) begin
            grant_q   <= grant_sel;
            payload_q <= bus.s_ar[grant_sel];
            drop_q    <= 1'b0;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (flush_now)     drop_q  <= 1'b1;
          if (bus.m_arready) state_q <= DATA;
        end
        DATA: begin
          if (flush_now) drop_q <= 1'b1;
          if (beat_hs) begin
            if (bus.m_rid != m_arid_c) rid_err_q <= 1'b1;
            if (bus.m_rlast) begin
              state_q <= IDLE;
              ptr_q   <= ~grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_arready = arready_c;
  assign bus.s_rvalid  = rvalid_c;
  assign bus.s_r       = s_r_c;
  assign bus.s_rlast   = s_rlast_c;
  assign bus.m_arvalid = m_arvalid_c;
  assign bus.m_ar      = m_ar_c;
  assign bus.m_arid    = m_arid_c;
  assign bus.m_rready  = m_rready_c;
  assign bus.rid_err   = rid_err_q;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: inputs change at the falling edge and
// outputs are checked 1 time unit later, away from the rising edge.
module tb_axi_rd_arb;
  localparam int unsigned IdW = defs_pkg::AxiIdW;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [44:0] p_ifu0, p_lsu, p_ifu3;
  logic [65:0] d;

  axi_rd_arb_if #(.AxiIdW(IdW)) bus ();

  axi_rd_arb #(.AxiIdW(IdW), .NReq(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic fail(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    errors++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    checks = 0;
    errors = 0;
    p_ifu0 = {32'h0000_1000, 8'd0, 3'd3, 2'b01};
    p_lsu  = {32'h8000_0040, 8'd3, 3'd3, 2'b01};
    p_ifu3 = {32'h0000_2000, 8'd3, 3'd3, 2'b01};

    rst_n         = 1'b0;
    bus.s_arvalid = 2'b11;
    bus.s_ar[0]   = p_ifu0;
    bus.s_ar[1]   = p_lsu;
    bus.s_flush   = 2'b00;
    bus.s_rready  = 2'b11;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rid     = '0;
    bus.m_r       = '0;
    bus.m_rlast   = 1'b0;

    // Reset values while requests are pending.
    @(negedge clk); @(negedge clk); #1;
    checks++; if (bus.s_arready !== 2'b00) fail("rst_arready", bus.s_arready, 2'b00);
    checks++; if (bus.m_arvalid !== 1'b0) fail("rst_arvalid", bus.m_arvalid, 1'b0);
    checks++; if (bus.m_ar !== 45'd0) fail("rst_mar", bus.m_ar, 45'd0);
    checks++; if (bus.m_arid !== IdW'(0)) fail("rst_arid", bus.m_arid, IdW'(0));
    checks++; if (bus.m_rready !== 1'b0) fail("rst_rready", bus.m_rready, 1'b0);
    checks++; if (bus.s_rvalid !== 2'b00) fail("rst_rvalid", bus.s_rvalid, 2'b00);
    checks++; if (bus.rid_err !== 1'b0) fail("rst_riderr", bus.rid_err, 1'b0);

    // Both request from reset: IFU first.
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (bus.s_arready !== 2'b01) fail("arb0_arready", bus.s_arready, 2'b01);
    @(negedge clk); #1;
    checks++; if (bus.s_arready !== 2'b00) fail("arb0_addr_arready", bus.s_arready, 2'b00);
    checks++; if (bus.m_arvalid !== 1'b1) fail("arb0_arvalid", bus.m_arvalid, 1'b1);
    checks++; if (bus.m_ar !== p_ifu0) fail("arb0_mar", bus.m_ar, p_ifu0);
    checks++; if (bus.m_arid !== IdW'(0)) fail("arb0_arid", bus.m_arid, IdW'(0));
    bus.m_arready = 1'b1;

    // Single-beat IFU burst.
    @(negedge clk);
    bus.m_arready = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rid = IdW'(0);
    d = {64'hDEAD_BEEF_0000_0001, 2'b00}; bus.m_r = d;
    #1;
    checks++; if (bus.s_rvalid !== 2'b01) fail("ifu1_rvalid", bus.s_rvalid, 2'b01);
    checks++; if (bus.m_rready !== 1'b1) fail("ifu1_rready", bus.m_rready, 1'b1);
    checks++; if (bus.s_r !== d) fail("ifu1_sr", bus.s_r, d);
    checks++; if (bus.s_rlast !== 1'b1) fail("ifu1_rlast", bus.s_rlast, 1'b1);

    // Back in IDLE: stale m_rvalid not acknowledged, LSU now preferred.
    @(negedge clk); #1;
    checks++; if (bus.m_rready !== 1'b0) fail("idle_rready", bus.m_rready, 1'b0);
    checks++; if (bus.s_rvalid !== 2'b00) fail("idle_rvalid", bus.s_rvalid, 2'b00);
    checks++; if (bus.s_arready !== 2'b10) fail("arb1_arready", bus.s_arready, 2'b10);
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;

    // LSU address held off for 5 cycles; payload stays latched.
    @(negedge clk);
    bus.s_ar[1] = ~p_lsu;
    #1;
    checks++; if (bus.m_arid !== IdW'(1)) fail("lsu_arid", bus.m_arid, IdW'(1));
    for (int unsigned i = 0; i < 5; i++) begin
      if (i != 0) begin @(negedge clk); #1; end
      checks++; if (bus.m_arvalid !== 1'b1) fail("stall_arvalid", bus.m_arvalid, 1'b1);
      checks++; if (bus.m_ar !== p_lsu) fail("stall_mar", bus.m_ar, p_lsu);
      checks++; if (bus.s_arready !== 2'b00) fail("stall_arready", bus.s_arready, 2'b00);
    end
    @(negedge clk); bus.m_arready = 1'b1; #1;
    checks++; if (bus.m_ar !== p_lsu) fail("stall_end_mar", bus.m_ar, p_lsu);

    // LSU 4-beat burst with backpressure on beat 2.
    @(negedge clk);
    bus.m_arready = 1'b0;
    bus.s_arvalid = 2'b01; bus.s_ar[0] = p_ifu3; bus.s_ar[1] = p_lsu;
    bus.m_rvalid = 1'b1; bus.m_rid = IdW'(1); bus.m_r = 66'h1;
    #1;
    checks++; if (bus.s_rvalid !== 2'b10) fail("lsu_b1_rvalid", bus.s_rvalid, 2'b10);
    checks++; if (bus.m_rready !== 1'b1) fail("lsu_b1_rready", bus.m_rready, 1'b1);
    checks++; if (bus.s_arready !== 2'b00) fail("lsu_data_arrdy", bus.s_arready, 2'b00);
    @(negedge clk); bus.m_r = 66'h2; bus.s_rready = 2'b01; #1;
    checks++; if (bus.m_rready !== 1'b0) fail("lsu_b2_hold_rready", bus.m_rready, 1'b0);
    checks++; if (bus.s_rvalid !== 2'b10) fail("lsu_b2_hold_rvalid", bus.s_rvalid, 2'b10);
    @(negedge clk); bus.s_rready = 2'b11; #1;
    checks++; if (bus.m_rready !== 1'b1) fail("lsu_b2_rready", bus.m_rready, 1'b1);
    checks++; if (bus.s_r !== 66'h2) fail("lsu_b2_sr", bus.s_r, 66'h2);
    @(negedge clk); bus.m_r = 66'h3; #1;
    checks++; if (bus.s_rvalid !== 2'b10) fail("lsu_b3_rvalid", bus.s_rvalid, 2'b10);
    @(negedge clk); bus.m_r = 66'h4; bus.m_rlast = 1'b1; #1;
    checks++; if (bus.s_rvalid !== 2'b10) fail("lsu_b4_rvalid", bus.s_rvalid, 2'b10);
    checks++; if (bus.s_rlast !== 1'b1) fail("lsu_b4_rlast", bus.s_rlast, 1'b1);

    // IDLE one cycle after the last beat; IFU accepted.
    @(negedge clk); bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; #1;
    checks++; if (bus.s_arready !== 2'b01) fail("lsu_done_arready", bus.s_arready, 2'b01);
    checks++; if (bus.rid_err !== 1'b0) fail("lsu_done_riderr", bus.rid_err, 1'b0);
    @(negedge clk); bus.s_arvalid = 2'b00; #1;
    checks++; if (bus.m_ar !== p_ifu3) fail("ifu3_mar", bus.m_ar, p_ifu3);
    checks++; if (bus.m_arid !== IdW'(0)) fail("ifu3_arid", bus.m_arid, IdW'(0));
    bus.m_arready = 1'b1;

    // IFU 4-beat burst flushed on beat 2; LSU flush on beat 1 is ignored.
    @(negedge clk);
    bus.m_arready = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rid = IdW'(0); bus.m_r = 66'h11; bus.s_flush = 2'b10;
    #1;
    checks++; if (bus.s_rvalid !== 2'b01) fail("fl_b1_rvalid", bus.s_rvalid, 2'b01);
    checks++; if (bus.m_rready !== 1'b1) fail("fl_b1_rready", bus.m_rready, 1'b1);
    @(negedge clk); bus.s_flush = 2'b01; bus.s_rready = 2'b00; bus.m_r = 66'h12; #1;
    checks++; if (bus.s_rvalid !== 2'b00) fail("fl_b2_rvalid", bus.s_rvalid, 2'b00);
    checks++; if (bus.m_rready !== 1'b1) fail("fl_b2_rready", bus.m_rready, 1'b1);
    @(negedge clk); bus.s_flush = 2'b00; bus.m_r = 66'h13; #1;
    checks++; if (bus.s_rvalid !== 2'b00) fail("fl_b3_rvalid", bus.s_rvalid, 2'b00);
    checks++; if (bus.m_rready !== 1'b1) fail("fl_b3_rready", bus.m_rready, 1'b1);
    @(negedge clk); bus.m_r = 66'h14; bus.m_rlast = 1'b1; #1;
    checks++; if (bus.s_rvalid !== 2'b00) fail("fl_b4_rvalid", bus.s_rvalid, 2'b00);
    checks++; if (bus.m_rready !== 1'b1) fail("fl_b4_rready", bus.m_rready, 1'b1);

    // Next IFU request accepted normally.
    @(negedge clk);
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b11;
    bus.s_arvalid = 2'b01; bus.s_ar[0] = p_ifu0;
    #1;
    checks++; if (bus.s_arready !== 2'b01) fail("fl_next_arready", bus.s_arready, 2'b01);
    @(negedge clk); bus.s_arvalid = 2'b00; bus.m_arready = 1'b1; #1;
    checks++; if (bus.m_ar !== p_ifu0) fail("fl_next_mar", bus.m_ar, p_ifu0);

    // Beat with wrong ID: still routed, rid_err sticks.
    @(negedge clk);
    bus.m_arready = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rid = IdW'(1); bus.m_rlast = 1'b1; bus.m_r = 66'h21;
    bus.s_rready = 2'b01;
    #1;
    checks++; if (bus.rid_err !== 1'b0) fail("rid_pre_err", bus.rid_err, 1'b0);
    checks++; if (bus.s_rvalid !== 2'b01) fail("rid_rvalid", bus.s_rvalid, 2'b01);
    checks++; if (bus.m_rready !== 1'b1) fail("rid_rready", bus.m_rready, 1'b1);
    @(negedge clk);
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b11; bus.s_arvalid = 2'b11;
    #1;
    checks++; if (bus.rid_err !== 1'b1) fail("rid_err_set", bus.rid_err, 1'b1);
    checks++; if (bus.s_arready !== 2'b10) fail("arb2_arready", bus.s_arready, 2'b10);
    @(negedge clk); bus.m_arready = 1'b1; #1;
    checks++; if (bus.rid_err !== 1'b1) fail("rid_err_hold", bus.rid_err, 1'b1);
    checks++; if (bus.m_arid !== IdW'(1)) fail("arb2_arid", bus.m_arid, IdW'(1));

    // Reset asserted mid-DATA: outputs drop immediately.
    @(negedge clk);
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rid = IdW'(1); bus.m_r = 66'h31;
    #1;
    checks++; if (bus.s_rvalid !== 2'b10) fail("mid_rvalid", bus.s_rvalid, 2'b10);
    #1; rst_n = 1'b0; #1;
    checks++; if (bus.s_rvalid !== 2'b00) fail("arst_rvalid", bus.s_rvalid, 2'b00);
    checks++; if (bus.m_rready !== 1'b0) fail("arst_rready", bus.m_rready, 1'b0);
    checks++; if (bus.s_arready !== 2'b00) fail("arst_arready", bus.s_arready, 2'b00);
    checks++; if (bus.m_arvalid !== 1'b0) fail("arst_arvalid", bus.m_arvalid, 1'b0);
    checks++; if (bus.m_arid !== IdW'(0)) fail("arst_arid", bus.m_arid, IdW'(0));
    checks++; if (bus.s_r !== 66'h0) fail("arst_sr", bus.s_r, 66'h0);
    checks++; if (bus.rid_err !== 1'b0) fail("arst_riderr", bus.rid_err, 1'b0);
    bus.m_rvalid = 1'b0;

    // After release: IFU first again.
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (bus.s_arready !== 2'b01) fail("post_arready", bus.s_arready, 2'b01);
    @(negedge clk); #1;
    checks++; if (bus.m_arid !== IdW'(0)) fail("post_arid", bus.m_arid, IdW'(0));
    checks++; if (bus.m_ar !== p_ifu0) fail("post_mar", bus.m_ar, p_ifu0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard ceiling so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_rd_arb.md
AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 Parameter AxiIdW, default defs_pkg::AxiIdW, width of the master AR/R ID fields.
REQ-002 Parameter NReq, fixed 2, requester count: index 0 is IFU fetch, index 1 is LSU load.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 s_arvalid  in  [1:0]  per-requester AR valid.
REQ-006 s_arready  out  [1:0]  per-requester AR ready.
REQ-007 s_ar  in  [1:0][44:0]  per-requester payload {araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0]}.
REQ-008 s_flush  in  [1:0]  requester discards its outstanding burst.
REQ-009 s_rvalid  out  [1:0]  per-requester R valid.
REQ-010 s_rready  in  [1:0]  per-requester R ready.
REQ-011 s_r  out  [65:0]  shared {rdata[63:0], rresp[1:0]}, broadcast to both requesters.
REQ-012 s_rlast  out  1  shared last-beat flag.
REQ-013 m_arvalid  out  1, m_arready  in  1, m_ar  out  [44:0]  master AR handshake and payload.
REQ-014 m_arid  out  [AxiIdW-1:0]  grant index, zero-extended.
REQ-015 m_rvalid  in  1, m_rready  out  1, m_rid  in  [AxiIdW-1:0]  master R handshake and ID.
REQ-016 m_r  in  [65:0], m_rlast  in  1  master R payload and last-beat flag.
REQ-017 rid_err  out  1  sticky: R beat arrived with m_rid != m_arid.

Function
REQ-018 FSM states are IDLE, ADDR, DATA; at most one burst is outstanding at any time.
REQ-019 IDLE: if any s_arvalid, grant = requester at priority pointer if valid, else the other.
- Same cycle: s_arready[grant]=1; s_ar[grant] latched into a payload register; drop flag cleared; next state ADDR.
REQ-020 s_arready SHALL be 0 in ADDR and DATA, and 0 for the non-granted requester.
REQ-021 ADDR: m_arvalid=1, m_ar = latched payload, stable until m_arready; on handshake -> DATA.
REQ-022 DATA, drop flag clear: s_rvalid[grant]=m_rvalid, m_rready=s_rready[grant], other s_rvalid=0.
REQ-023 DATA, drop flag set: m_rready=1, s_rvalid=0 (beats consumed and discarded).
REQ-024 s_flush[grant] high in ADDR or DATA sets the drop flag.
- Flush in the same cycle as a beat handshake suppresses that beat (s_rvalid=0).
- s_flush of a non-granted requester is ignored.
REQ-025 On m_rvalid && m_rready && m_rlast: next state IDLE; priority pointer = ~grant.
REQ-026 Latency: s_arvalid in IDLE at cycle 0 -> s_arready cycle 0, m_arvalid from cycle 1.
- After the rlast handshake in cycle n, a new request is acceptable in cycle n+1.
REQ-027 R beat handshake with m_rid != m_arid sets rid_err; beat is still routed or dropped normally.
REQ-028 m_rvalid outside DATA is not acknowledged (m_rready=0).
REQ-029 arlen=0 single-beat bursts SHALL complete DATA in one handshake.

Reset
REQ-030 Reset value of every output is 0; state=IDLE, pointer=0 (IFU preferred), drop flag=0, rid_err=0.
REQ-031 Reset mid-burst returns to IDLE immediately; the R beats still owed by the slave are not tracked.
- The external system resets the AXI slave together with this block.

Verification
REQ-032 s_arvalid=2'b11 from reset -> IFU granted first (m_ar = IFU payload, m_arid=0); LSU granted after IFU rlast (m_arid=1).
REQ-033 LSU arlen=3, IFU idle -> 4 beats routed to s_rvalid[1] only.
- s_rready[1] low on beat 2 -> m_rready low and beat held; IDLE one cycle after the 4th beat.
REQ-034 m_arready held low 5 cycles -> m_arvalid and m_ar stable throughout; s_arready stays 0 for both.
REQ-035 IFU arlen=3, s_flush[0] pulsed after beat 1 -> beats 2-4 consumed with m_rready=1.
- s_rvalid[0] stays 0; next IFU request is accepted normally.
REQ-036 m_rid=1 while m_arid=0 -> rid_err rises on that beat and stays 1 until rst_n asserted.
REQ-037 rst_n asserted in DATA -> all outputs 0 asynchronously; first request after release is arbitrated IFU-first.
